tms_k_debounce: RTL and testbench

//   Input conditioner directly upstream of the tms1x00 core's K inputs and chip-select input.

---
 rtl/tms_k_debounce_if.sv | 36 +++
 rtl/tms_k_debounce.sv | 92 +++++++++
 tb/tb_tms_k_debounce.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tms_k_debounce_if.sv
// Signal bundle between the K/chip-select pads and the keypad conditioner.
// TMS_KDEB_EDGE_EN adds the k_edge_o / press_cnt_o outputs.
interface tms_k_debounce_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] k_raw_i;
    logic             cs_raw_i;
    logic [CNT_W-1:0] db_limit_i;
    logic             hold_i;
    logic [WIDTH-1:0] k_o;
    logic             cs_o;
    logic             k_stable_o;
`ifdef TMS_KDEB_EDGE_EN
    logic [WIDTH-1:0] k_edge_o;
    logic [7:0]       press_cnt_o;

    modport master (
        output k_raw_i, cs_raw_i, db_limit_i, hold_i,
        input  k_o, cs_o, k_stable_o, k_edge_o, press_cnt_o
    );
    modport slave (
        input  k_raw_i, cs_raw_i, db_limit_i, hold_i,
        output k_o, cs_o, k_stable_o, k_edge_o, press_cnt_o
    );
`else
    modport master (
        output k_raw_i, cs_raw_i, db_limit_i, hold_i,
        input  k_o, cs_o, k_stable_o
    );
    modport slave (
        input  k_raw_i, cs_raw_i, db_limit_i, hold_i,
        output k_o, cs_o, k_stable_o
    );
`endif
endinterface

// File: rtl/tms_k_debounce.sv
// Synchronises and debounces the tms1x00 K inputs and synchronises chip select.
// Optional edge pulses / press counter are built when TMS_KDEB_EDGE_EN is defined.
module tms_k_debounce #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    tms_k_debounce_if.slave  bus
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] k_sync_q;
    logic [SYNC_STAGES-1:0]            cs_sync_q;
    logic [WIDTH-1:0]                  k_s;
    logic [WIDTH-1:0]                  k_q, k_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;

    assign k_s = k_sync_q[SYNC_STAGES-1];

    // Synchronisers are never frozen; only the debounce state honours hold_i.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            k_sync_q  <= '0;
            cs_sync_q <= '0;
        end else begin
            k_sync_q  <= {k_sync_q[SYNC_STAGES-2:0], bus.k_raw_i};
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_raw_i};
        end
    end

    always_comb begin
        k_d   = k_q;
        cnt_d = cnt_q;
        if (!bus.hold_i) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (k_s[i] == k_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= bus.db_limit_i) begin
                    k_d[i]   = k_s[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            k_q   <= k_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.k_o        = k_q;
    assign bus.cs_o       = cs_sync_q[SYNC_STAGES-1];
    assign bus.k_stable_o = ~|(k_s ^ k_q);

`ifdef TMS_KDEB_EDGE_EN
    logic [WIDTH-1:0] k_prev_q;
    logic [WIDTH-1:0] k_edge_q;
    logic [7:0]       press_cnt_q, press_cnt_d;

    // Rising bits this edge; several bits rising together add several counts.
    always_comb begin
        press_cnt_d = press_cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            press_cnt_d = press_cnt_d + {7'd0, k_d[i] & ~k_q[i]};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            k_prev_q    <= '0;
            k_edge_q    <= '0;
            press_cnt_q <= '0;
        end else begin
            k_prev_q    <= k_q;
            k_edge_q    <= k_q ^ k_prev_q;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bus.k_edge_o    = k_edge_q;
    assign bus.press_cnt_o = press_cnt_q;
`endif

endmodule

// File: tb/tb_tms_k_debounce.sv
// Directed self-checking bench for tms_k_debounce.
// Edge-feature checks run only when TMS_KDEB_EDGE_EN is defined.
module tb_tms_k_debounce;

    logic wb_clk;
    logic wb_rst_n;
    int   checks;
    int   errors;
    int   pulse_cnt;
    logic edge_prev;

    tms_k_debounce_if #(.WIDTH(4), .CNT_W(8)) bus ();

    tms_k_debounce #(
        .WIDTH       (4),
        .CNT_W       (8),
        .SYNC_STAGES (2)
    ) dut (
        .wb_clk_i  (wb_clk),
        .wb_rst_ni (wb_rst_n),
        .bus       (bus.slave)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
`ifdef TMS_KDEB_EDGE_EN
        if (bus.k_edge_o[2]) begin
            pulse_cnt++;
            check("edge_single_cycle", {31'd0, edge_prev}, 32'd0);
        end
        edge_prev = bus.k_edge_o[2];
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        pulse_cnt  = 0;
        edge_prev  = 1'b0;
        wb_rst_n   = 1'b1;
        bus.k_raw_i    = 4'b0000;
        bus.cs_raw_i   = 1'b0;
        bus.db_limit_i = 8'd3;
        bus.hold_i     = 1'b0;

        // Reset asserted between clock edges
        #2 wb_rst_n = 1'b0;
        #1;
        check("rst_k", {28'd0, bus.k_o}, 32'h0);
        check("rst_cs", {31'd0, bus.cs_o}, 32'h0);
        check("rst_stable", {31'd0, bus.k_stable_o}, 32'h1);
        ticks(2);
        wb_rst_n = 1'b1;
        ticks(2);

        // Settled press: k_o after 6 edges, k_stable low after edges 2..5
        bus.db_limit_i = 8'd3;
        bus.k_raw_i    = 4'b0101;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("press_k", {28'd0, bus.k_o}, (e == 6) ? 32'h5 : 32'h0);
            check("press_stable", {31'd0, bus.k_stable_o}, (e >= 2 && e <= 5) ? 32'h0 : 32'h1);
        end

        // Release and settle back to 0000
        bus.k_raw_i = 4'b0000;
        ticks(10);
        check("release_k", {28'd0, bus.k_o}, 32'h0);

        // Glitch on bit 0 for 3 cycles must be rejected
        bus.k_raw_i = 4'b0001;
        ticks(3);
        bus.k_raw_i = 4'b0000;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("glitch_k", {28'd0, bus.k_o}, 32'h0);
        end
        check("glitch_stable", {31'd0, bus.k_stable_o}, 32'h1);

        // Pass-through with db_limit 0: 3-edge latency; cs 2-edge latency
        bus.db_limit_i = 8'd0;
        bus.k_raw_i    = 4'b1000;
        bus.cs_raw_i   = 1'b1;
        tick();
        check("cs_edge1", {31'd0, bus.cs_o}, 32'h0);
        tick();
        check("cs_edge2", {31'd0, bus.cs_o}, 32'h1);
        check("pass_edge2", {28'd0, bus.k_o}, 32'h0);
        tick();
        check("pass_edge3", {28'd0, bus.k_o}, 32'h8);
        bus.k_raw_i = 4'b0000;
        ticks(2);
        check("pass_fall_edge2", {28'd0, bus.k_o}, 32'h8);
        tick();
        check("pass_fall_edge3", {28'd0, bus.k_o}, 32'h0);

        // Hold on the edge the update is due (edge 5 with limit 2)
        bus.db_limit_i = 8'd2;
        bus.k_raw_i    = 4'b0010;
        ticks(4);
        check("hold_pre", {28'd0, bus.k_o}, 32'h0);
        bus.hold_i = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("hold_k", {28'd0, bus.k_o}, 32'h0);
        end
        bus.hold_i = 1'b0;
        tick();
        check("hold_release_k", {28'd0, bus.k_o}, 32'h2);

        // Mid-operation reset, then full latency after release
        #3 wb_rst_n = 1'b0;
        #1;
        check("midrst_k", {28'd0, bus.k_o}, 32'h0);
        check("midrst_cs", {31'd0, bus.cs_o}, 32'h0);
        check("midrst_stable", {31'd0, bus.k_stable_o}, 32'h1);
        tick();
        wb_rst_n = 1'b1;
        ticks(4);
        check("post_rst_edge4", {28'd0, bus.k_o}, 32'h0);
        tick();
        check("post_rst_edge5", {28'd0, bus.k_o}, 32'h2);

        // Lowering the limit below a running count updates on the next edge
        bus.db_limit_i = 8'd5;
        bus.k_raw_i    = 4'b0000;
        ticks(6);
        check("limit_drop_pre", {28'd0, bus.k_o}, 32'h2);
        bus.db_limit_i = 8'd1;
        tick();
        check("limit_drop_post", {28'd0, bus.k_o}, 32'h0);

        // Independent bits: bit 2 joins two edges later and settles two edges later
        bus.db_limit_i = 8'd3;
        bus.k_raw_i    = 4'b0011;
        ticks(2);
        bus.k_raw_i = 4'b0111;
        ticks(4);
        check("indep_edge6", {28'd0, bus.k_o}, 32'h3);
        tick();
        check("indep_edge7", {28'd0, bus.k_o}, 32'h3);
        tick();
        check("indep_edge8", {28'd0, bus.k_o}, 32'h7);

`ifdef TMS_KDEB_EDGE_EN
        // 256 press/release cycles on bit 2 from a clean reset
        bus.k_raw_i    = 4'b0000;
        bus.db_limit_i = 8'd0;
        #3 wb_rst_n = 1'b0;
        #1;
        check("edge_rst_press", {24'd0, bus.press_cnt_o}, 32'h0);
        tick();
        wb_rst_n  = 1'b1;
        ticks(2);
        pulse_cnt = 0;
        edge_prev = 1'b0;
        for (int n = 0; n < 256; n++) begin
            bus.k_raw_i = 4'b0100;
            ticks(4);
            bus.k_raw_i = 4'b0000;
            ticks(4);
        end
        check("edge_pulses", pulse_cnt, 32'd512);
        check("press_wrap", {24'd0, bus.press_cnt_o}, 32'h0);

        // Three bits rising together add three counts
        bus.k_raw_i = 4'b0111;
        ticks(3);
        check("multi_press_cnt", {24'd0, bus.press_cnt_o}, 32'h3);
        tick();
        check("multi_edge", {28'd0, bus.k_edge_o}, 32'h7);
        tick();
        check("multi_edge_clear", {28'd0, bus.k_edge_o}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
